jpeg_frame_ctrl: RTL and testbench

Per-frame sequencer for `jpeg_package`. It accepts a frame request and holds the packager in reset between frames. It gates `Compress_data_rdy` from the entropy-coder FIFO level and monitors the packaged byte stream for SOI/EOI markers and stalls. On completion it reports frame length, frame count and error status to the host.

---
 rtl/jpeg_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_jpeg_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_frame_ctrl.sv
// Per-frame sequencer for jpeg_package: packager reset, data gating, SOI/EOI and stall
// monitoring, and end-of-frame status reporting to the host.
module jpeg_frame_ctrl #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned ARM_THRESH = 64,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned LEN_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_req,
    input  logic             frame_abort,
    input  logic [11:0]      cfifo_level,
    input  logic             cfifo_eof,
    output logic             pkg_rst_n,
    output logic             Compress_data_rdy,
    input  logic [7:0]       jpeg_data,
    input  logic             jpeg_data_vaild,
    input  logic             jpeg_data_last,
    output logic             frame_busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [LEN_W-1:0] frame_len,
    output logic [15:0]      frame_cnt
);
    localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] CodeOk      = 2'd0;
    localparam logic [1:0] CodeTimeout = 2'd1;
    localparam logic [1:0] CodeMarker  = 2'd2;
    localparam logic [1:0] CodeAbort   = 2'd3;

    typedef enum logic [2:0] {StIdle, StClear, StArm, StRun, StFin} state_e;

    state_e             state_q, state_d;
    logic [RcW-1:0]     rcnt_q, rcnt_d;
    logic [TW-1:0]      idle_q, idle_d;
    logic [LEN_W-1:0]   bcnt_q, bcnt_d;
    logic [7:0]         prev_q, prev_d;
    logic               soi_bad_q, soi_bad_d;
    logic [1:0]         pend_q, pend_d;
    logic               pkg_rst_n_q, pkg_rst_n_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [15:0]        fcnt_q, fcnt_d;

    logic               eoi_ok;
    logic               arm_go;

    assign arm_go = (32'(cfifo_level) >= ARM_THRESH) || cfifo_eof;
    // A valid EOI needs a preceding byte of FF ahead of the D9 that carries last.
    assign eoi_ok = (bcnt_q != '0) && (prev_q == 8'hFF) && (jpeg_data == 8'hD9);

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        idle_d    = idle_q;
        bcnt_d    = bcnt_q;
        prev_d    = prev_q;
        soi_bad_d = soi_bad_q;
        pend_d    = pend_q;
        done_d    = 1'b0;
        err_d     = err_q;
        code_d    = code_q;
        len_d     = len_q;
        fcnt_d    = fcnt_q;

        unique case (state_q)
            StIdle: begin
                if (frame_req) begin
                    state_d   = StClear;
                    err_d     = 1'b0;
                    code_d    = CodeOk;
                    bcnt_d    = '0;
                    rcnt_d    = '0;
                    pend_d    = CodeOk;
                    soi_bad_d = 1'b0;
                end
            end
            StClear: begin
                if (frame_abort) begin
                    state_d = StFin;
                    pend_d  = CodeAbort;
                end else if (rcnt_q == RcW'(RST_CYCLES - 1)) begin
                    state_d = StArm;
                end else begin
                    rcnt_d = rcnt_q + RcW'(1);
                end
            end
            StArm: begin
                if (frame_abort) begin
                    state_d = StFin;
                    pend_d  = CodeAbort;
                end else if (arm_go) begin
                    state_d = StRun;
                    idle_d  = '0;
                end
            end
            StRun: begin
                if (jpeg_data_vaild) begin
                    if (bcnt_q != '1) bcnt_d = bcnt_q + LEN_W'(1);
                    prev_d = jpeg_data;
                    idle_d = '0;
                    if (bcnt_q == LEN_W'(0) && jpeg_data != 8'hFF) soi_bad_d = 1'b1;
                    if (bcnt_q == LEN_W'(1) && jpeg_data != 8'hD8) soi_bad_d = 1'b1;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
                if (frame_abort) begin
                    state_d = StFin;
                    pend_d  = CodeAbort;
                end else if (!jpeg_data_vaild && idle_q == TW'(TIMEOUT - 1)) begin
                    state_d = StFin;
                    pend_d  = CodeTimeout;
                end else if (jpeg_data_vaild && jpeg_data_last) begin
                    state_d = StFin;
                    pend_d  = (soi_bad_d || !eoi_ok) ? CodeMarker : CodeOk;
                end
            end
            StFin: begin
                state_d = StIdle;
                done_d  = 1'b1;
                len_d   = bcnt_q;
                err_d   = (pend_q != CodeOk);
                code_d  = pend_q;
                if (pend_q == CodeOk) fcnt_d = fcnt_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with it.
        pkg_rst_n_d = (state_d == StArm) || (state_d == StRun) ||
                      ((state_d == StFin) && pkg_rst_n_q);
        rdy_d       = (state_q == StRun) && (state_d == StRun) &&
                      ((cfifo_level != 12'd0) || cfifo_eof);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rcnt_q      <= '0;
            idle_q      <= '0;
            bcnt_q      <= '0;
            prev_q      <= '0;
            soi_bad_q   <= 1'b0;
            pend_q      <= CodeOk;
            pkg_rst_n_q <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= CodeOk;
            len_q       <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            idle_q      <= idle_d;
            bcnt_q      <= bcnt_d;
            prev_q      <= prev_d;
            soi_bad_q   <= soi_bad_d;
            pend_q      <= pend_d;
            pkg_rst_n_q <= pkg_rst_n_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
            len_q       <= len_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign pkg_rst_n         = pkg_rst_n_q;
    assign Compress_data_rdy = rdy_q;
    assign frame_busy        = busy_q;
    assign frame_done        = done_q;
    assign frame_err         = err_q;
    assign err_code          = code_q;
    assign frame_len         = len_q;
    assign frame_cnt         = fcnt_q;

endmodule

// File: tb/tb_jpeg_frame_ctrl.sv
// Self-checking bench for jpeg_frame_ctrl: vector table, directed corner sequences and
// randomized frames scored against a marker/length model of the frame rules.
module tb_jpeg_frame_ctrl;
    localparam int RSTC = 4;
    localparam int THR  = 64;
    localparam int TMO  = 100;
    localparam int LW   = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_req = 1'b0;
    logic          frame_abort = 1'b0;
    logic [11:0]   cfifo_level = 12'd0;
    logic          cfifo_eof = 1'b0;
    logic          pkg_rst_n;
    logic          Compress_data_rdy;
    logic [7:0]    jpeg_data = 8'd0;
    logic          jpeg_data_vaild = 1'b0;
    logic          jpeg_data_last = 1'b0;
    logic          frame_busy;
    logic          frame_done;
    logic          frame_err;
    logic [1:0]    err_code;
    logic [LW-1:0] frame_len;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    jpeg_frame_ctrl #(
        .RST_CYCLES(RSTC),
        .ARM_THRESH(THR),
        .TIMEOUT   (TMO),
        .LEN_W     (LW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_req        (frame_req),
        .frame_abort      (frame_abort),
        .cfifo_level      (cfifo_level),
        .cfifo_eof        (cfifo_eof),
        .pkg_rst_n        (pkg_rst_n),
        .Compress_data_rdy(Compress_data_rdy),
        .jpeg_data        (jpeg_data),
        .jpeg_data_vaild  (jpeg_data_vaild),
        .jpeg_data_last   (jpeg_data_last),
        .frame_busy       (frame_busy),
        .frame_done       (frame_done),
        .frame_err        (frame_err),
        .err_code         (err_code),
        .frame_len        (frame_len),
        .frame_cnt        (frame_cnt)
    );

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2, b3;
        bit         ab;
        int         exp_code;
        int         exp_len;
    } vec_t;

    vec_t        tbl[7];
    logic [7:0]  bq[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned good_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two markers at each end, random payload in between.
    task automatic fill(input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
        bq[0]   = b0;
        bq[1]   = b1;
        bq[n-2] = b2;
        bq[n-1] = b3;
    endtask

    function automatic int model_code(input bit ab);
        int n = bq.size();
        if (ab) return 3;
        if (n >= 2 && bq[0] == 8'hFF && bq[1] == 8'hD8 && bq[n-2] == 8'hFF &&
            bq[n-1] == 8'hD9) return 0;
        return 2;
    endfunction

    task automatic start_frame();
        int k;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        chk("req_clears_err", {29'd0, frame_err, err_code}, 32'd0);
        chk("busy_after_req", frame_busy, 1);
        k = 1;
        while (!pkg_rst_n && k < 20) begin
            tick();
            k++;
        end
        chk("clear_cycles", k, RSTC + 1);
    endtask

    task automatic wait_rdy();
        int k = 0;
        while (!Compress_data_rdy && k < 50) begin
            tick();
            k++;
        end
        chk("wait_rdy", Compress_data_rdy, 1);
    endtask

    task automatic send_bytes(input int gapmax, input bit abort_last, input bit do_last);
        int n = bq.size();
        for (int i = 0; i < n; i++) begin
            jpeg_data       = bq[i];
            jpeg_data_vaild = 1'b1;
            jpeg_data_last  = do_last && (i == n - 1);
            frame_abort     = abort_last && (i == n - 1);
            tick();
            jpeg_data_vaild = 1'b0;
            jpeg_data_last  = 1'b0;
            frame_abort     = 1'b0;
            if (i < n - 1) repeat ($urandom_range(gapmax, 0)) tick();
        end
    endtask

    // Called in the FIN cycle; status becomes visible in the following (IDLE) cycle.
    task automatic finish_frame(input string tag, input int exp_code, input int exp_len);
        chk({tag, "_fin_done"}, frame_done, 0);
        chk({tag, "_fin_busy"}, frame_busy, 1);
        tick();
        if (exp_code == 0) good_cnt++;
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_idle_busy"}, frame_busy, 0);
        chk({tag, "_idle_rstn"}, pkg_rst_n, 0);
        chk({tag, "_len"}, frame_len, exp_len);
        chk({tag, "_code"}, err_code, exp_code);
        chk({tag, "_err"}, frame_err, exp_code != 0);
        chk({tag, "_cnt"}, frame_cnt, good_cnt & 32'hFFFF);
        tick();
        chk({tag, "_done_pulse"}, frame_done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int viol;
        tbl[0] = '{1000, 8'hFF, 8'hD8, 8'hFF, 8'hD9, 1'b0, 0, 1000};
        tbl[1] = '{10,   8'hFF, 8'hD8, 8'h12, 8'h34, 1'b0, 2, 10};
        tbl[2] = '{4,    8'hFF, 8'hD8, 8'hFF, 8'hD9, 1'b0, 0, 4};
        tbl[3] = '{6,    8'hFF, 8'hD0, 8'hFF, 8'hD9, 1'b0, 2, 6};
        tbl[4] = '{6,    8'h00, 8'hD8, 8'hFF, 8'hD9, 1'b0, 2, 6};
        tbl[5] = '{8,    8'hFF, 8'hD8, 8'hFE, 8'hD9, 1'b0, 2, 8};
        tbl[6] = '{5,    8'hFF, 8'hD8, 8'hFF, 8'hD9, 1'b1, 3, 5};

        tick();
        chk("rst_pkg_rst_n", pkg_rst_n, 0);
        chk("rst_rdy", Compress_data_rdy, 0);
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", {29'd0, frame_err, err_code}, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_cnt", frame_cnt, 0);
        rst = 1'b0;
        tick();

        cfifo_level = 12'd100;
        for (int t = 0; t < 7; t++) begin
            start_frame();
            wait_rdy();
            fill(tbl[t].n, tbl[t].b0, tbl[t].b1, tbl[t].b2, tbl[t].b3);
            send_bytes((tbl[t].n > 100) ? 0 : 2, tbl[t].ab, 1'b1);
            finish_frame($sformatf("vec%0d", t), tbl[t].exp_code, tbl[t].exp_len);
        end

        // ARM must hold off until the FIFO threshold is met.
        cfifo_level = 12'd10;
        start_frame();
        viol = 0;
        repeat (500) begin
            tick();
            if (Compress_data_rdy || !pkg_rst_n || !frame_busy) viol++;
        end
        chk("arm_hold", viol, 0);
        cfifo_level = 12'd64;
        tick();
        chk("arm_run_first_rdy", Compress_data_rdy, 0);
        tick();
        chk("arm_run_rdy", Compress_data_rdy, 1);
        fill(12, 8'hFF, 8'hD8, 8'hFF, 8'hD9);
        send_bytes(1, 1'b0, 1'b1);
        finish_frame("arm", 0, 12);

        // Timeout: 10 bytes, then silence.
        cfifo_level = 12'd100;
        start_frame();
        wait_rdy();
        fill(10, 8'hFF, 8'hD8, 8'h00, 8'h11);
        send_bytes(0, 1'b0, 1'b0);
        repeat (TMO) tick();
        finish_frame("timeout", 1, 10);

        // Abort while waiting in ARM.
        cfifo_level = 12'd0;
        start_frame();
        repeat (3) tick();
        chk("arm_wait_busy", frame_busy, 1);
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        finish_frame("abort_arm", 3, 0);

        // Request during RUN is dropped; reset mid-frame.
        cfifo_level = 12'd100;
        start_frame();
        wait_rdy();
        fill(60, 8'hFF, 8'hD8, 8'hFF, 8'hD9);
        for (int i = 0; i < 49; i++) begin
            jpeg_data       = bq[i];
            jpeg_data_vaild = 1'b1;
            tick();
            jpeg_data_vaild = 1'b0;
            if (i == 20) begin
                frame_req = 1'b1;
                tick();
                frame_req = 1'b0;
                tick();
                chk("req_in_run_busy", frame_busy, 1);
                chk("req_in_run_rstn", pkg_rst_n, 1);
                chk("req_in_run_rdy", Compress_data_rdy, 1);
            end
        end
        jpeg_data       = bq[49];
        jpeg_data_vaild = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rstn", pkg_rst_n, 0);
        chk("midrst_rdy", Compress_data_rdy, 0);
        chk("midrst_busy", frame_busy, 0);
        chk("midrst_status", {frame_done, frame_err, err_code, frame_cnt}, 0);
        chk("midrst_len", frame_len, 0);
        jpeg_data_vaild = 1'b0;
        tick();
        rst = 1'b0;
        good_cnt = 0;
        tick();
        start_frame();
        wait_rdy();
        fill(20, 8'hFF, 8'hD8, 8'hFF, 8'hD9);
        send_bytes(2, 1'b0, 1'b1);
        finish_frame("after_rst", 0, 20);

        // Randomized frames against the marker/length model.
        for (int r = 0; r < 25; r++) begin
            int  n;
            int  kind;
            bit  ab;
            n    = $urandom_range(60, 4);
            kind = $urandom_range(3, 0);
            ab   = (kind == 3);
            cfifo_level = 12'($urandom_range(4095, THR));
            fill(n, 8'hFF, 8'hD8, 8'hFF, 8'hD9);
            if (kind == 1) bq[$urandom_range(1, 0)] ^= 8'($urandom_range(255, 1));
            if (kind == 2) bq[n - 1 - $urandom_range(1, 0)] ^= 8'($urandom_range(255, 1));
            start_frame();
            wait_rdy();
            send_bytes(3, ab, 1'b1);
            finish_frame($sformatf("rand%0d", r), model_code(ab), n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
